// File: rtl/power_governor.sv
// Power governor: picks the accumulator setting and add/drain mode from the requested setting,
// dock status and fed-back power level. It soft-starts, derates, locks out when empty and charges.
module power_governor #(
  parameter int unsigned MAX_LEVEL      = 179,
  parameter int unsigned LOW_THRESH     = 32,
  parameter int unsigned RESTART_THRESH = 64,
  parameter int unsigned STEP_CYCLES    = 4,
  parameter int unsigned WARN_PERIOD    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req_setting,
  input  logic       i_req_valid,
  input  logic       i_dock,
  input  logic [7:0] i_power_level,
  output logic [1:0] o_power_setting,
  output logic       o_power_mode,
  output logic [2:0] o_state,
  output logic       o_low_warn,
  output logic       o_fault,
  output logic       o_full
);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StRun     = 3'd1,
    StDerate  = 3'd2,
    StLockout = 3'd3,
    StCharge  = 3'd4
  } state_e;

  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned BW = (WARN_PERIOD > 1) ? $clog2(WARN_PERIOD) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(WARN_PERIOD - 1);
  localparam logic [8:0]    MAX_L      = 9'(MAX_LEVEL);
  localparam logic [8:0]    LOW_L      = 9'(LOW_THRESH);
  localparam logic [8:0]    RESTART_L  = 9'(RESTART_THRESH);

  state_e        r_state;
  logic [1:0]    r_target;
  logic [1:0]    r_setting;
  logic          r_mode;
  logic          r_low_warn;
  logic          r_fault;
  logic          r_full;
  logic [SW-1:0] r_step_cnt;
  logic [BW-1:0] r_blink_cnt;

  state_e        w_state_d;
  logic [1:0]    w_target_eff;
  logic [1:0]    w_target_d;
  logic [1:0]    w_setting_d;
  logic          w_mode_d;
  logic          w_low_warn_d;
  logic          w_fault_d;
  logic          w_full_d;
  logic [SW-1:0] w_step_d;
  logic [BW-1:0] w_blink_d;
  logic [8:0]    w_lvl;

  // Over-range levels saturate at the ceiling; 9 bits keep level+3 from wrapping.
  assign w_lvl = ({1'b0, i_power_level} > MAX_L) ? MAX_L : {1'b0, i_power_level};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StOff;
      r_target    <= 2'd0;
      r_setting   <= 2'd0;
      r_mode      <= 1'b1;
      r_low_warn  <= 1'b0;
      r_fault     <= 1'b0;
      r_full      <= 1'b0;
      r_step_cnt  <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_target    <= w_target_d;
      r_setting   <= w_setting_d;
      r_mode      <= w_mode_d;
      r_low_warn  <= w_low_warn_d;
      r_fault     <= w_fault_d;
      r_full      <= w_full_d;
      r_step_cnt  <= w_step_d;
      r_blink_cnt <= w_blink_d;
    end
  end

  always_comb begin
    w_target_eff = r_target;
    if (i_req_valid && (r_state != StLockout) && (r_state != StCharge)) begin
      w_target_eff = i_req_setting;
    end
    w_target_d = i_dock ? 2'd0 : w_target_eff;

    w_state_d = r_state;
    if (i_dock) begin
      w_state_d = StCharge;
    end else begin
      case (r_state)
        StOff: begin
          if (i_req_valid && (i_req_setting != 2'd0)) w_state_d = StRun;
        end
        StRun, StDerate: begin
          if (w_lvl == 9'd0)                            w_state_d = StLockout;
          else if (w_target_eff == 2'd0)                w_state_d = StOff;
          else if ((r_state == StRun) && (w_lvl <= LOW_L)) w_state_d = StDerate;
        end
        StLockout: w_state_d = StLockout;
        StCharge:  w_state_d = (w_lvl >= RESTART_L) ? StOff : StLockout;
        default:   w_state_d = StOff;
      endcase
    end
  end

  // Next values for the registered outputs; counters default to 0 so any state change clears them.
  always_comb begin
    w_setting_d  = 2'd0;
    w_mode_d     = 1'b1;
    w_low_warn_d = 1'b0;
    w_fault_d    = 1'b0;
    w_full_d     = 1'b0;
    w_step_d     = '0;
    w_blink_d    = '0;
    case (w_state_d)
      StRun: begin
        if (r_state != StRun) begin
          w_setting_d = 2'd1;
        end else if (w_target_eff < r_setting) begin
          w_setting_d = w_target_eff;
        end else if (w_target_eff > r_setting) begin
          w_setting_d = r_setting;
          if (r_step_cnt == STEP_LAST) w_setting_d = r_setting + 2'd1;
          else                         w_step_d    = r_step_cnt + SW'(1);
        end else begin
          w_setting_d = r_setting;
        end
      end
      StDerate: begin
        w_setting_d = {1'b0, |w_target_eff};
        if (r_state == StDerate) begin
          w_low_warn_d = r_low_warn;
          if (r_blink_cnt == BLINK_LAST) w_low_warn_d = ~r_low_warn;
          else                           w_blink_d    = r_blink_cnt + BW'(1);
        end
      end
      StLockout: w_fault_d = 1'b1;
      StCharge: begin
        w_mode_d = 1'b0;
        if ((w_lvl + 9'd3) < MAX_L) w_setting_d = 2'd3;
        else if (w_lvl < MAX_L)     w_setting_d = 2'd1;
        else                        w_full_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state         = r_state;
  assign o_power_setting = r_setting;
  assign o_power_mode    = r_mode;
  assign o_low_warn      = r_low_warn;
  assign o_fault         = r_fault;
  assign o_full          = r_full;

endmodule

// File: tb/tb_power_governor.sv
// Bench for power_governor: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural model of the governor's rules.
module tb_power_governor;

  localparam int MAX = 179, LOW = 32, RST_T = 64, STEP = 4, WARN = 8;
  localparam int S_OFF = 0, S_RUN = 1, S_DER = 2, S_LOCK = 3, S_CHG = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req_setting = 2'd0;
  logic       req_valid = 1'b0;
  logic       dock = 1'b0;
  logic [7:0] power_level = 8'd0;
  logic [1:0] power_setting;
  logic       power_mode;
  logic [2:0] state;
  logic       low_warn;
  logic       fault;
  logic       full;

  int n_vec = 0, n_err = 0;
  int m_state, m_target, m_set, m_mode, m_warn, m_fault, m_full, m_step, m_blink;

  power_governor dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_setting  (req_setting),
    .i_req_valid    (req_valid),
    .i_dock         (dock),
    .i_power_level  (power_level),
    .o_power_setting(power_setting),
    .o_power_mode   (power_mode),
    .o_state        (state),
    .o_low_warn     (low_warn),
    .o_fault        (fault),
    .o_full         (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_OFF; m_target = 0; m_set = 0; m_mode = 1; m_warn = 0;
    m_fault = 0; m_full = 0; m_step = 0; m_blink = 0;
  endtask

  task automatic model_edge(input int d, input int lvl_in, input int rv, input int rs);
    int lvl, prev, teff, nxt;
    lvl  = (lvl_in > MAX) ? MAX : lvl_in;
    prev = m_state;
    teff = (rv != 0 && prev != S_LOCK && prev != S_CHG) ? rs : m_target;
    if (d != 0)                            nxt = S_CHG;
    else if (prev == S_OFF)                nxt = (rv != 0 && rs != 0) ? S_RUN : S_OFF;
    else if (prev == S_RUN || prev == S_DER) begin
      if (lvl == 0)                        nxt = S_LOCK;
      else if (teff == 0)                  nxt = S_OFF;
      else if (prev == S_RUN && lvl <= LOW) nxt = S_DER;
      else                                 nxt = prev;
    end else if (prev == S_LOCK)           nxt = S_LOCK;
    else                                   nxt = (lvl >= RST_T) ? S_OFF : S_LOCK;
    m_target = (d != 0) ? 0 : teff;
    if (nxt != S_RUN || prev != S_RUN) m_step = 0;
    if (nxt != S_DER || prev != S_DER) begin m_blink = 0; m_warn = 0; end
    case (nxt)
      S_OFF, S_LOCK: m_set = 0;
      S_RUN: begin
        if (prev != S_RUN) m_set = 1;
        else if (teff < m_set) begin m_set = teff; m_step = 0; end
        else if (teff > m_set) begin
          m_step++;
          if (m_step == STEP) begin m_set++; m_step = 0; end
        end else m_step = 0;
      end
      S_DER: begin
        m_set = (teff < 1) ? teff : 1;
        if (prev == S_DER) begin
          m_blink++;
          if (m_blink == WARN) begin m_warn ^= 1; m_blink = 0; end
        end
      end
      default: m_set = (lvl + 3 < MAX) ? 3 : (lvl < MAX) ? 1 : 0;
    endcase
    m_mode  = (nxt == S_CHG) ? 0 : 1;
    m_fault = (nxt == S_LOCK) ? 1 : 0;
    m_full  = (nxt == S_CHG && lvl >= MAX) ? 1 : 0;
    m_state = nxt;
  endtask

  task automatic check_model(input string where);
    check({where, ".state"},   state,         m_state);
    check({where, ".setting"}, power_setting, m_set);
    check({where, ".mode"},    power_mode,    m_mode);
    check({where, ".warn"},    low_warn,      m_warn);
    check({where, ".fault"},   fault,         m_fault);
    check({where, ".full"},    full,          m_full);
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, ".state"},   state,         0);
    check({where, ".setting"}, power_setting, 0);
    check({where, ".mode"},    power_mode,    1);
    check({where, ".warn"},    low_warn,      0);
    check({where, ".fault"},   fault,         0);
    check({where, ".full"},    full,          0);
  endtask

  task automatic tick(input logic rv, input logic [1:0] rs, input logic d, input logic [7:0] lvl);
    req_valid = rv; req_setting = rs; dock = d; power_level = lvl;
    @(posedge clk);
    if (rst_n) model_edge(int'(d), int'(lvl), int'(rv), int'(rs));
    #1;
    check_model("model");
    req_valid = 1'b0;
  endtask

  initial begin
    int lv_tab[12] = '{0, 1, 31, 32, 33, 63, 64, 65, 175, 176, 178, 179};
    logic       r_dock;
    logic [7:0] r_lvl;

    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick(1'b1, 2'd3, 1'b1, 8'd0);
    tick(1'b0, 2'd0, 1'b0, 8'd100);
    rst_n = 1'b1;

    // Soft start toward hilted setting
    tick(1'b1, 2'd3, 1'b0, 8'd100);
    check("run_entry.state", state, 1);
    check("run_entry.setting", power_setting, 1);
    for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 1'b0, 8'd100);
    check("soft_hold.setting", power_setting, 1);
    tick(1'b0, 2'd0, 1'b0, 8'd100);
    check("soft_step2.setting", power_setting, 2);
    for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 1'b0, 8'd100);
    check("soft_step3.setting", power_setting, 3);
    check("soft_step3.mode", power_mode, 1);

    // Derate, blink, then empty
    tick(1'b0, 2'd0, 1'b0, 8'd32);
    check("derate.state", state, 2);
    check("derate.setting", power_setting, 1);
    for (int i = 0; i < 7; i++) tick(1'b0, 2'd0, 1'b0, 8'd20);
    check("blink_pre.warn", low_warn, 0);
    tick(1'b0, 2'd0, 1'b0, 8'd20);
    check("blink_on.warn", low_warn, 1);
    tick(1'b0, 2'd0, 1'b0, 8'd0);
    check("lockout.state", state, 3);
    check("lockout.fault", fault, 1);
    check("lockout.setting", power_setting, 0);

    // Lockout ignores requests; charge taper
    tick(1'b1, 2'd2, 1'b0, 8'd100);
    check("lock_ignore.state", state, 3);
    tick(1'b0, 2'd0, 1'b1, 8'd100);
    check("charge.state", state, 4);
    check("charge.mode", power_mode, 0);
    check("charge.setting", power_setting, 3);
    tick(1'b0, 2'd0, 1'b1, 8'd176);
    check("taper.setting", power_setting, 1);
    tick(1'b0, 2'd0, 1'b1, 8'd179);
    check("full.setting", power_setting, 0);
    check("full.full", full, 1);

    // Undock below and at restart threshold
    tick(1'b0, 2'd0, 1'b0, 8'd40);
    check("undock_low.state", state, 3);
    tick(1'b0, 2'd0, 1'b1, 8'd100);
    tick(1'b0, 2'd0, 1'b0, 8'd64);
    check("undock_ok.state", state, 0);
    check("undock_ok.fault", fault, 0);

    // Dock wins over empty and request in the same cycle
    tick(1'b1, 2'd2, 1'b0, 8'd100);
    tick(1'b1, 2'd3, 1'b1, 8'd0);
    check("dock_prio.state", state, 4);
    check("dock_prio.target", dut.r_target, 0);

    // Asynchronous reset mid-cycle while charging
    tick(1'b0, 2'd0, 1'b1, 8'd100);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    rst_n = 1'b1;
    tick(1'b0, 2'd0, 1'b1, 8'd100);
    check("post_reset_dock.state", state, 4);
    tick(1'b0, 2'd0, 1'b0, 8'd100);

    // Randomized traffic
    r_dock = 1'b0;
    r_lvl  = 8'd100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) r_dock = ~r_dock;
      if ($urandom_range(9) < 3) begin
        if ($urandom_range(9) < 6) r_lvl = 8'(lv_tab[$urandom_range(11)]);
        else                       r_lvl = 8'($urandom_range(255));
      end
      tick(($urandom_range(3) == 0), 2'($urandom_range(3)), r_dock, r_lvl);
      if ((i % 300) == 299) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_model("rand_reset");
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/power_governor.md
POWER_GOVERNOR -- requirements
Module: power_governor

Interface
REQ-001 Parameter MAX_LEVEL, default 179: ceiling of the power level counter.
REQ-002 Parameter LOW_THRESH, default 32: level at or below which draw is derated.
REQ-003 Parameter RESTART_THRESH, default 64: minimum level to leave lockout when undocked.
REQ-004 Parameter STEP_CYCLES, default 4: cycles between single-step setting increases (soft start).
REQ-005 Parameter WARN_PERIOD, default 8: cycles per low_warn toggle.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 req_setting  input  2  requested setting: 0 off, 1 single, 2 double, 3 hilted.
REQ-009 req_valid  input  1  one-cycle strobe; captures req_setting into target register.
REQ-010 dock  input  1  charger connected, level-sensitive.
REQ-011 power_level  input  8  current level fed back from the power accumulator, unsigned.
REQ-012 power_setting  output  2  setting driven to the power accumulator.
REQ-013 power_mode  output  1  0 = add (charge), 1 = subtract (drain).
REQ-014 state  output  3  encoded FSM state: OFF=0, RUN=1, DERATE=2, LOCKOUT=3, CHARGE=4.
REQ-015 low_warn  output  1  blinking low-power indicator.
REQ-016 fault  output  1  high while in LOCKOUT.
REQ-017 full  output  1  high while in CHARGE with power_level >= MAX_LEVEL.

Function
REQ-018 All outputs shall be registered; a condition sampled at edge N is visible after edge N.
REQ-019 Event priority per cycle shall be: dock, then power_level == 0, then req_valid, then threshold tests.
REQ-020 req_valid shall load target; in LOCKOUT and CHARGE it shall be ignored and target left unchanged.
REQ-021 OFF: power_setting=0, power_mode=1; req_valid with nonzero setting -> RUN with power_setting=1.
REQ-022 RUN: power_mode=1; power_setting shall rise toward target by one step every STEP_CYCLES cycles and drop to target immediately when target < power_setting.
REQ-023 RUN: target==0 -> OFF; power_level <= LOW_THRESH -> DERATE.
REQ-024 DERATE: power_setting=min(target,1); low_warn toggles every WARN_PERIOD cycles, 0 in all other states.
REQ-025 DERATE: target==0 -> OFF; power_level==0 -> LOCKOUT; no return to RUN without passing through CHARGE.
REQ-026 RUN or DERATE with power_level==0 shall go to LOCKOUT regardless of req_valid that cycle.
REQ-027 LOCKOUT: power_setting=0, power_mode=1, fault=1; only dock exits (-> CHARGE).
REQ-028 CHARGE: entered from any state when dock=1; power_mode=0; target cleared to 0 on entry.
REQ-029 CHARGE: power_setting=3 while power_level < MAX_LEVEL-3; 1 while MAX_LEVEL-3 <= power_level < MAX_LEVEL; 0 and full=1 at power_level >= MAX_LEVEL.
REQ-030 CHARGE with dock=0: -> OFF if power_level >= RESTART_THRESH, else -> LOCKOUT.
REQ-031 Soft-start step counter shall reset to 0 on every setting change and on every state change.
REQ-032 Blink counter shall wrap at WARN_PERIOD-1 and clear on leaving DERATE.
REQ-033 power_level > MAX_LEVEL shall be treated as MAX_LEVEL; no arithmetic overflow in comparisons.

Reset
REQ-034 rst=0 shall immediately force state=OFF, power_setting=0, power_mode=1, low_warn=0, fault=0, full=0, target=0, all counters=0.
REQ-035 Reset asserted mid-operation (including LOCKOUT or CHARGE) shall abandon it; after release the block shall start in OFF and sample dock on the first edge.

Verification
REQ-036 Reset release, power_level=100, req_valid with req_setting=3 -> RUN; power_setting 1, 2, 3 at STEP_CYCLES intervals; power_mode=1.
REQ-037 In RUN setting 3, power_level falls to 32 -> DERATE, power_setting=1, low_warn toggles every 8 cycles; power_level=0 -> LOCKOUT, fault=1, power_setting=0.
REQ-038 In LOCKOUT, req_valid setting 2 -> no change; dock=1 -> CHARGE, power_mode=0, power_setting=3; power_level=176 -> 1; 179 -> 0 and full=1.
REQ-039 CHARGE, power_level=40, dock=0 -> LOCKOUT; repeat with power_level=64 -> OFF, fault=0.
REQ-040 Same-cycle dock=1, power_level=0, req_valid=1 in RUN -> CHARGE, target=0.
REQ-041 rst=0 asserted asynchronously mid-cycle in CHARGE -> all outputs at reset values before next clk edge.
